d_branch_ctrl: RTL and testbench
================================

D_BRANCH_CTRL -- requirements
Module: d_branch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; its ports SHALL be as listed in REQ-002 to REQ-017.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 d_valid  in  1  D stage holds a valid instruction.
REQ-005 d_hold  in  1  D frozen by another hazard; no resolution this cycle.
REQ-006 d_cmpop  in  4  0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 bltz, 6 blez; 7-15 treated as none.
REQ-007 d_rs_ready / d_rt_ready  in  1 each  forwarded rs/rt value final this cycle.
REQ-008 d_rd1 / d_rd2  in  32 each  forwarded rs/rt values.
REQ-009 d_pc  in  32  PC of D instruction.
REQ-010 d_offset  in  16  branch immediate.
REQ-011 flush  in  1  synchronous abort (exception/eret).
REQ-012 stall  out  1  freeze F/D, bubble into E.
REQ-013 br_taken  out  1  one-cycle pulse in resolution cycle when condition true.
REQ-014 redirect_valid / redirect_pc  out  1 / 32  registered fetch redirect.
REQ-015 br_cnt / taken_cnt  out  16 each  resolved / taken branch counters.
REQ-016 ds_err  out  1  sticky: branch in delay slot.
REQ-017 wait_err  out  1  sticky: operand wait exceeded 7 cycles.

Function
REQ-018 Branch SHALL mean d_valid=1 and d_cmpop in 1..6; beq/bne use rs and rt readiness, others use rs only.
REQ-019 Conditions SHALL be: beq rd1==rd2; bne rd1!=rd2; bgez/bgtz/bltz/blez compare rd1 as signed two's-complement against 0.
REQ-020 Target SHALL be d_pc+4+(sign_ext(d_offset)<<2), modulo 2^32.
REQ-021 FSM states SHALL be IDLE, WAIT, REDIR.
REQ-022 IDLE: a branch with d_hold=0 and required operands ready SHALL resolve combinationally that cycle (stall=0), going to REDIR if taken, else staying in IDLE.
REQ-023 IDLE: a branch with d_hold=0 and a required operand not ready SHALL assert stall combinationally that cycle, go to WAIT and clear the wait counter.
REQ-024 WAIT: stall SHALL be 1 until the cycle operands are ready; that cycle stall=0, the branch resolves, and the next state is REDIR if taken, else IDLE.
REQ-025 WAIT: the 3-bit wait counter SHALL increment each non-ready cycle and saturate at 7; a non-ready cycle at count 7 SHALL set wait_err, with the FSM remaining in WAIT.
REQ-026 A taken resolution SHALL latch the target; in REDIR, redirect_valid=1 and redirect_pc=the latched target for exactly one cycle, then IDLE.
REQ-027 REDIR: a branch in D (delay slot) SHALL be ignored (not resolved, not counted, no stall) and SHALL set ds_err.
REQ-028 d_hold=1 SHALL block resolution in every state, but the WAIT counter SHALL still advance.
REQ-029 flush=1 SHALL have top priority: next state IDLE, counter cleared, redirect cancelled, stall=0 and br_taken=0 that cycle; counters and sticky errors SHALL be kept.
REQ-030 Each resolution SHALL increment br_cnt, and taken_cnt if taken; both SHALL saturate at 0xFFFF.
REQ-031 br_taken SHALL be 0 in every non-resolution cycle.
REQ-032 Redirect latency SHALL be exactly one cycle after the resolution edge.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, wait counter 0, stall 0, br_taken 0, redirect_valid 0, redirect_pc 0, br_cnt 0, taken_cnt 0, ds_err 0, wait_err 0.
REQ-034 Reset mid-WAIT or mid-REDIR SHALL drop stall and redirect_valid immediately, without waiting for a clock edge.
REQ-035 After rst_n deasserts, the block SHALL act on the first rising edge.

Verification
REQ-036 beq, rd1=rd2=0x1234, ready, pc=0x3000, offset=0x0004 -> br_taken=1 and stall=0 that cycle; next cycle redirect_valid=1, redirect_pc=0x3014; br_cnt=1, taken_cnt=1.
REQ-037 bgtz, rd1=0x80000000, ready -> not taken (signed), no redirect, br_cnt=1, taken_cnt=0.
REQ-038 bne, rt not ready for 2 cycles -> stall=1 for 2 cycles, resolve in the 3rd with stall=0; offset=0xFFFF, pc=0x3000 -> redirect_pc=0x3000.
REQ-039 rs never ready -> stall held, wait_err=1 on the 8th non-ready cycle; then flush -> IDLE, stall=0, wait_err stays 1.
REQ-040 Taken branch followed by a branch in the delay slot during REDIR -> ds_err=1, br_cnt increments only once.
REQ-041 rst_n low for half a cycle during REDIR -> redirect_valid=0 immediately; counters=0.

Source files
------------

// File: rtl/d_branch_ctrl.sv
// rtl/d_branch_ctrl.sv - decode-stage branch resolution, operand-wait stall and fetch redirect
module d_branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic        d_hold,
  input  logic [3:0]  d_cmpop,
  input  logic        d_rs_ready,
  input  logic        d_rt_ready,
  input  logic [31:0] d_rd1,
  input  logic [31:0] d_rd2,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_offset,
  input  logic        flush,
  output logic        stall,
  output logic        br_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] br_cnt,
  output logic [15:0] taken_cnt,
  output logic        ds_err,
  output logic        wait_err
);

  typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] target_q;
  logic [31:0] target;
  logic        is_br, two_op, ops_ready, cond;
  logic        resolve, stall_c, set_ds, set_we;

  always_comb begin
    is_br     = d_valid && (d_cmpop >= 4'd1) && (d_cmpop <= 4'd6);
    two_op    = (d_cmpop == 4'd1) || (d_cmpop == 4'd2);
    ops_ready = d_rs_ready && (!two_op || d_rt_ready);
    target    = d_pc + 32'd4 + {{14{d_offset[15]}}, d_offset, 2'b00};
    case (d_cmpop)
      4'd1:    cond = (d_rd1 == d_rd2);
      4'd2:    cond = (d_rd1 != d_rd2);
      4'd3:    cond = !d_rd1[31];
      4'd4:    cond = !d_rd1[31] && (d_rd1 != 32'd0);
      4'd5:    cond = d_rd1[31];
      4'd6:    cond = d_rd1[31] || (d_rd1 == 32'd0);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    resolve      = 1'b0;
    stall_c      = 1'b0;
    set_ds       = 1'b0;
    set_we       = 1'b0;
    if (flush) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_br && !d_hold) begin
            if (ops_ready) begin
              resolve   = 1'b1;
              state_nxt = cond ? REDIR : IDLE;
            end else begin
              stall_c      = 1'b1;
              state_nxt    = WAIT;
              wait_cnt_nxt = 3'd0;
            end
          end
        end
        WAIT: begin
          if (!is_br) begin
            state_nxt    = IDLE;
            wait_cnt_nxt = 3'd0;
          end else if (!d_hold && ops_ready) begin
            resolve      = 1'b1;
            state_nxt    = cond ? REDIR : IDLE;
            wait_cnt_nxt = 3'd0;
          end else begin
            // held cycles still age the wait; only a genuinely unready operand at the limit is an error
            stall_c = 1'b1;
            if (wait_cnt == 3'd7) set_we = !ops_ready;
            else                  wait_cnt_nxt = wait_cnt + 3'd1;
          end
        end
        REDIR: begin
          state_nxt = IDLE;
          set_ds    = is_br;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // combinational outputs are gated so reset drops them without a clock edge
  assign stall          = stall_c && rst_n;
  assign br_taken       = resolve && cond && rst_n;
  assign redirect_valid = (state == REDIR);
  assign redirect_pc    = target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      target_q  <= 32'd0;
      br_cnt    <= 16'd0;
      taken_cnt <= 16'd0;
      ds_err    <= 1'b0;
      wait_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (resolve && cond) target_q <= target;
      if (resolve && (br_cnt != 16'hFFFF)) br_cnt <= br_cnt + 16'd1;
      if (resolve && cond && (taken_cnt != 16'hFFFF)) taken_cnt <= taken_cnt + 16'd1;
      if (set_ds) ds_err <= 1'b1;
      if (set_we) wait_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_d_branch_ctrl.sv
// tb/tb_d_branch_ctrl.sv - scoreboard bench for d_branch_ctrl
module tb_d_branch_ctrl;

  logic        clk, rst_n;
  logic        d_valid, d_hold, d_rs_ready, d_rt_ready, flush;
  logic [3:0]  d_cmpop;
  logic [31:0] d_rd1, d_rd2, d_pc;
  logic [15:0] d_offset;
  logic        stall, br_taken, redirect_valid, ds_err, wait_err;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt, taken_cnt;

  d_branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_hold(d_hold), .d_cmpop(d_cmpop),
    .d_rs_ready(d_rs_ready), .d_rt_ready(d_rt_ready), .d_rd1(d_rd1), .d_rd2(d_rd2),
    .d_pc(d_pc), .d_offset(d_offset), .flush(flush), .stall(stall), .br_taken(br_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .br_cnt(br_cnt),
    .taken_cnt(taken_cnt), .ds_err(ds_err), .wait_err(wait_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_STALL = 0, S_TAKEN = 1, S_RV = 2, S_RPC = 3, S_BRC = 4, S_TKC = 5, S_DS = 6, S_WE = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pc;
    logic [15:0] off;
    logic        rt, br, tk;
    logic [31:0] tgt;
  } tc_t;

  exp_t sb_q[$];
  tc_t  tbl[16];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_br = 0;
  int   exp_tk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      S_STALL: return {31'd0, stall};
      S_TAKEN: return {31'd0, br_taken};
      S_RV:    return {31'd0, redirect_valid};
      S_RPC:   return redirect_pc;
      S_BRC:   return {16'd0, br_cnt};
      S_TKC:   return {16'd0, taken_cnt};
      S_DS:    return {31'd0, ds_err};
      default: return {31'd0, wait_err};
    endcase
  endfunction

  always @(negedge clk) begin : sampler
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, sig(e.sel), e.val);
    end
  end

  task automatic expect_sig(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rs, input logic rt, input logic [31:0] pc, input logic [15:0] off);
    d_valid = 1'b1; d_cmpop = op; d_rd1 = a; d_rd2 = b;
    d_rs_ready = rs; d_rt_ready = rt; d_pc = pc; d_offset = off;
  endtask

  task automatic none();
    d_valid = 1'b0; d_cmpop = 4'd0; d_hold = 1'b0; flush = 1'b0;
    d_rs_ready = 1'b1; d_rt_ready = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'd1, 32'd5, 32'd5, 32'h1000, 16'h0001, 1'b1, 1'b1, 1'b1, 32'h0000_1008};
    tbl[1]  = '{4'd1, 32'd5, 32'd6, 32'h1100, 16'h0001, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{4'd2, 32'd5, 32'd6, 32'h2000, 16'h0010, 1'b1, 1'b1, 1'b1, 32'h0000_2044};
    tbl[3]  = '{4'd2, 32'd7, 32'd7, 32'h2100, 16'h0010, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{4'd3, 32'd0, 32'd9, 32'h0000, 16'h8000, 1'b0, 1'b1, 1'b1, 32'hFFFE_0004};
    tbl[5]  = '{4'd3, 32'hFFFF_FFFF, 32'd0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{4'd4, 32'd0, 32'd0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{4'd4, 32'd1, 32'd0, 32'hFFFF_FFF0, 16'h0004, 1'b0, 1'b1, 1'b1, 32'h0000_0004};
    tbl[8]  = '{4'd4, 32'h8000_0000, 32'd0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{4'd5, 32'h8000_0000, 32'd0, 32'h4000, 16'hFFFE, 1'b0, 1'b1, 1'b1, 32'h0000_3FFC};
    tbl[10] = '{4'd5, 32'd0, 32'd0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{4'd6, 32'd0, 32'd3, 32'h5000, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_5004};
    tbl[12] = '{4'd6, 32'h7FFF_FFFF, 32'd0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{4'd7, 32'd0, 32'd0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{4'd0, 32'd0, 32'd0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{4'd5, 32'hFFFF_FFFF, 32'd0, 32'h0100, 16'h7FFF, 1'b0, 1'b1, 1'b1, 32'h0002_0100};

    rst_n = 1'b0;
    none();
    d_rd1 = 32'd0; d_rd2 = 32'd0; d_pc = 32'd0; d_offset = 16'd0;

    // in reset, an unready branch must not raise stall
    cyc();
    drive(4'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 16'h0);
    expect_sig("rst_stall", S_STALL, 0); expect_sig("rst_taken", S_TAKEN, 0);
    expect_sig("rst_rv", S_RV, 0);       expect_sig("rst_rpc", S_RPC, 0);
    expect_sig("rst_brc", S_BRC, 0);     expect_sig("rst_tkc", S_TKC, 0);
    expect_sig("rst_ds", S_DS, 0);       expect_sig("rst_we", S_WE, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    none();

    // beq taken, one-cycle redirect
    cyc(); drive(4'd1, 32'h1234, 32'h1234, 1'b1, 1'b1, 32'h3000, 16'h0004);
    expect_sig("beq_stall", S_STALL, 0); expect_sig("beq_taken", S_TAKEN, 1); expect_sig("beq_rv0", S_RV, 0);
    exp_br++; exp_tk++;
    cyc(); none();
    expect_sig("beq_rv", S_RV, 1); expect_sig("beq_rpc", S_RPC, 32'h3014); expect_sig("beq_taken0", S_TAKEN, 0);
    expect_sig("beq_brc", S_BRC, 1); expect_sig("beq_tkc", S_TKC, 1);
    cyc(); expect_sig("beq_rv_end", S_RV, 0);

    // bgtz on a negative operand is not taken
    cyc(); drive(4'd4, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'h3000, 16'h0004);
    expect_sig("bgtz_stall", S_STALL, 0); expect_sig("bgtz_taken", S_TAKEN, 0);
    exp_br++;
    cyc(); none();
    expect_sig("bgtz_rv", S_RV, 0); expect_sig("bgtz_brc", S_BRC, exp_br); expect_sig("bgtz_tkc", S_TKC, exp_tk);

    for (int i = 0; i < 16; i++) begin
      cyc(); drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].rt, tbl[i].pc, tbl[i].off);
      expect_sig($sformatf("tbl%0d_stall", i), S_STALL, 0);
      expect_sig($sformatf("tbl%0d_taken", i), S_TAKEN, {31'd0, tbl[i].tk});
      if (tbl[i].br) exp_br++;
      if (tbl[i].tk) exp_tk++;
      cyc(); none();
      expect_sig($sformatf("tbl%0d_rv", i), S_RV, {31'd0, tbl[i].tk});
      if (tbl[i].tk) expect_sig($sformatf("tbl%0d_rpc", i), S_RPC, tbl[i].tgt);
      expect_sig($sformatf("tbl%0d_brc", i), S_BRC, exp_br);
      expect_sig($sformatf("tbl%0d_tkc", i), S_TKC, exp_tk);
    end

    // bne with rt late by two cycles, backward-by-one target
    cyc(); drive(4'd2, 32'd1, 32'd2, 1'b1, 1'b0, 32'h3000, 16'hFFFF);
    expect_sig("bne_w1_stall", S_STALL, 1); expect_sig("bne_w1_taken", S_TAKEN, 0);
    cyc(); expect_sig("bne_w2_stall", S_STALL, 1); expect_sig("bne_w2_taken", S_TAKEN, 0);
    cyc(); d_rt_ready = 1'b1;
    expect_sig("bne_res_stall", S_STALL, 0); expect_sig("bne_res_taken", S_TAKEN, 1);
    exp_br++; exp_tk++;
    cyc(); none();
    expect_sig("bne_rv", S_RV, 1); expect_sig("bne_rpc", S_RPC, 32'h3000); expect_sig("bne_brc", S_BRC, exp_br);

    // rs never ready; one held-but-ready cycle must still age the counter
    cyc(); drive(4'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 16'h0);
    expect_sig("wt_c1_stall", S_STALL, 1);
    for (int c = 2; c <= 9; c++) begin
      cyc();
      d_hold = (c == 5); d_rs_ready = (c == 5);
      expect_sig($sformatf("wt_c%0d_stall", c), S_STALL, 1);
      expect_sig($sformatf("wt_c%0d_taken", c), S_TAKEN, 0);
      expect_sig($sformatf("wt_c%0d_we", c), S_WE, 0);
    end
    cyc(); d_hold = 1'b0; d_rs_ready = 1'b0;
    expect_sig("wt_c10_stall", S_STALL, 1); expect_sig("wt_c10_we", S_WE, 1);
    cyc(); flush = 1'b1; d_rs_ready = 1'b1;
    expect_sig("wt_flush_stall", S_STALL, 0); expect_sig("wt_flush_taken", S_TAKEN, 0); expect_sig("wt_flush_we", S_WE, 1);
    cyc(); none();
    expect_sig("wt_post_stall", S_STALL, 0); expect_sig("wt_post_we", S_WE, 1); expect_sig("wt_post_brc", S_BRC, exp_br);
    cyc(); drive(4'd3, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'h0, 16'h0);
    expect_sig("wt_idle_stall", S_STALL, 0); expect_sig("wt_idle_taken", S_TAKEN, 0);
    exp_br++;
    cyc(); none(); expect_sig("wt_idle_brc", S_BRC, exp_br); expect_sig("wt_idle_rv", S_RV, 0);

    // hold in IDLE defers resolution by one cycle
    cyc(); drive(4'd1, 32'd9, 32'd9, 1'b1, 1'b1, 32'h3000, 16'h0004); d_hold = 1'b1;
    expect_sig("hold_stall", S_STALL, 0); expect_sig("hold_taken", S_TAKEN, 0);
    cyc(); d_hold = 1'b0;
    expect_sig("hold_rel_taken", S_TAKEN, 1); expect_sig("hold_brc", S_BRC, exp_br);
    exp_br++; exp_tk++;
    cyc(); none();
    expect_sig("hold_rv", S_RV, 1); expect_sig("hold_rpc", S_RPC, 32'h3014); expect_sig("hold_brc2", S_BRC, exp_br);

    // flush beats a ready taken branch
    cyc(); drive(4'd1, 32'd9, 32'd9, 1'b1, 1'b1, 32'h3000, 16'h0008); flush = 1'b1;
    expect_sig("fl_taken", S_TAKEN, 0); expect_sig("fl_stall", S_STALL, 0);
    cyc(); none();
    expect_sig("fl_rv", S_RV, 0); expect_sig("fl_brc", S_BRC, exp_br); expect_sig("fl_tkc", S_TKC, exp_tk);

    // branch in the delay slot is ignored and flagged
    cyc(); drive(4'd1, 32'd3, 32'd3, 1'b1, 1'b1, 32'h6000, 16'h0002);
    expect_sig("ds_taken", S_TAKEN, 1);
    exp_br++; exp_tk++;
    cyc(); drive(4'd1, 32'd3, 32'd3, 1'b1, 1'b1, 32'h6004, 16'h0002);
    expect_sig("ds_slot_taken", S_TAKEN, 0); expect_sig("ds_slot_stall", S_STALL, 0);
    expect_sig("ds_slot_rv", S_RV, 1); expect_sig("ds_slot_rpc", S_RPC, 32'h600C); expect_sig("ds_before", S_DS, 0);
    cyc(); none();
    expect_sig("ds_err", S_DS, 1); expect_sig("ds_brc", S_BRC, exp_br); expect_sig("ds_tkc", S_TKC, exp_tk);
    expect_sig("ds_rv", S_RV, 0);

    // half-cycle reset pulse in REDIR
    cyc(); drive(4'd1, 32'd0, 32'd0, 1'b1, 1'b1, 32'h7000, 16'h0000);
    expect_sig("ar_taken", S_TAKEN, 1);
    cyc(); drive(4'd3, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 16'h0);
    check("ar_rv_pre", {31'd0, redirect_valid}, 1);
    expect_sig("ar_rv_neg", S_RV, 0);   expect_sig("ar_stall_neg", S_STALL, 0);
    expect_sig("ar_brc_neg", S_BRC, 0); expect_sig("ar_tkc_neg", S_TKC, 0);
    expect_sig("ar_ds_neg", S_DS, 0);   expect_sig("ar_we_neg", S_WE, 0);
    expect_sig("ar_rpc_neg", S_RPC, 0);
    #1 rst_n = 1'b0;
    #1 check("ar_rv_async", {31'd0, redirect_valid}, 0);
    check("ar_brc_async", {16'd0, br_cnt}, 0);
    #4 rst_n = 1'b1;
    exp_br = 0; exp_tk = 0;
    cyc(); drive(4'd1, 32'd4, 32'd4, 1'b1, 1'b1, 32'h0100, 16'h0000);
    expect_sig("ar_first_taken", S_TAKEN, 1); expect_sig("ar_first_stall", S_STALL, 0);
    cyc(); none();
    expect_sig("ar_first_rv", S_RV, 1); expect_sig("ar_first_rpc", S_RPC, 32'h0104);
    expect_sig("ar_first_brc", S_BRC, 1); expect_sig("ar_first_tkc", S_TKC, 1);

    cyc();
    @(negedge clk);
    #1;
    check("queue_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
